seg14_scroll_scanner: RTL and testbench



---
 rtl/seg14_scroll_scanner.sv | 92 +++++++++
 tb/tb_seg14_scroll_scanner.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg14_scroll_scanner.sv
// seg14_scroll_scanner: multiplexed 14-segment driver scanning a host-written message, static or scrolling
module seg14_scroll_scanner #(
   parameter  int N_DIGITS      = 12,
   parameter  int MSG_DEPTH     = 32,
   parameter  int SCAN_DIV      = 1,
   parameter  int SCROLL_FRAMES = 64,
   localparam int AW = $clog2(MSG_DEPTH),
   localparam int DW = $clog2(N_DIGITS),
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1,
   localparam int FW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [13:0]         wr_data,
   input  logic [AW:0]         msg_len,
   input  logic                scroll_en,
   input  logic                blank,
   output logic [N_DIGITS-1:0] sel,
   output logic [13:0]         segm,
   output logic                frame_tick
);
   logic [CW-1:0]       div_cnt_q, div_cnt_d;
   logic [DW-1:0]       d_q, d_d;
   logic [AW-1:0]       off_q, off_d, ptr_q, ptr_d, p_eff, p_next, off_next, d_idx;
   logic [FW-1:0]       fc_q, fc_d;
   logic [13:0]         mem_q [MSG_DEPTH];
   logic [13:0]         mem_d [MSG_DEPTH];
   logic [N_DIGITS-1:0] sel_q, sel_d;
   logic [13:0]         segm_q, segm_d, glyph, static_g;
   logic                frame_tick_q, frame_tick_d;
   logic [AW:0]         len_eff;
   logic                scan_tick, last_d, frame_end, step;

   assign sel        = sel_q;
   assign segm       = segm_q;
   assign frame_tick = frame_tick_q;

   // Scan timing, scroll offset, read pointer, glyph selection and buffer write
   always_comb begin
      len_eff   = (msg_len > (AW+1)'(MSG_DEPTH)) ? (AW+1)'(MSG_DEPTH) : msg_len;
      scan_tick = (div_cnt_q == CW'(SCAN_DIV-1));
      last_d    = (d_q == DW'(N_DIGITS-1));
      frame_end = scan_tick && last_d;
      step      = frame_end && (fc_q == FW'(SCROLL_FRAMES-1));
      div_cnt_d = scan_tick ? '0 : div_cnt_q + 1'b1;
      d_d       = !scan_tick ? d_q : last_d ? '0 : d_q + 1'b1;
      off_next  = (({1'b0, off_q} + 1'b1) >= len_eff) ? '0 : off_q + 1'b1;
      off_d     = !scroll_en ? '0 : !frame_end ? off_q : ({1'b0, off_q} >= len_eff) ? '0 :
                  step ? off_next : off_q;
      fc_d      = !scroll_en ? '0 : !frame_end ? fc_q : step ? '0 : fc_q + 1'b1;
      // a pointer left beyond a shrunken message restarts the walk at entry 0
      p_eff     = ({1'b0, ptr_q} >= len_eff) ? '0 : ptr_q;
      p_next    = (({1'b0, p_eff} + 1'b1) >= len_eff) ? '0 : p_eff + 1'b1;
      // each frame begins at the offset that will be current for it
      ptr_d     = !scan_tick ? ptr_q : last_d ? off_d : p_next;
      d_idx     = AW'(d_q);
      static_g  = (int'(d_q) < int'(len_eff)) ? mem_q[d_idx] : '0;
      glyph     = (len_eff == '0) ? '0 : scroll_en ? mem_q[p_eff] : static_g;
      sel_d     = !scan_tick ? sel_q : blank ? '0 : {{(N_DIGITS-1){1'b0}}, 1'b1} << d_q;
      segm_d    = !scan_tick ? segm_q : blank ? '0 : glyph;
      frame_tick_d = frame_end;
      mem_d     = mem_q;
      if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_DEPTH))) mem_d[wr_addr] = wr_data;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q    <= '0;
         d_q          <= '0;
         off_q        <= '0;
         ptr_q        <= '0;
         fc_q         <= '0;
         sel_q        <= '0;
         segm_q       <= '0;
         frame_tick_q <= 1'b0;
         for (int i = 0; i < MSG_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         div_cnt_q    <= div_cnt_d;
         d_q          <= d_d;
         off_q        <= off_d;
         ptr_q        <= ptr_d;
         fc_q         <= fc_d;
         sel_q        <= sel_d;
         segm_q       <= segm_d;
         frame_tick_q <= frame_tick_d;
         mem_q        <= mem_d;
      end
   end
endmodule

// File: tb/tb_seg14_scroll_scanner.sv
// tb_seg14_scroll_scanner: directed checks of scan order, static padding, scrolling, blanking and boundaries
module tb_seg14_scroll_scanner;
   localparam int N = 4, M = 8, AW = 3;
   logic          clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, scroll_en = 1'b0, blank = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [13:0]   wr_data = '0;
   logic [AW:0]   msg_len = '0;
   logic [N-1:0]  sel;
   logic [13:0]   segm;
   logic          frame_tick;
   int            n_tests = 0, n_fail = 0;
   logic [13:0]   g [M];
   logic [N-1:0]  cs [N];
   logic [13:0]   cq [N];
   logic [N-1:0]  es;
   logic [13:0]   eq;

   always #5 clk = ~clk;

   seg14_scroll_scanner #(.N_DIGITS(N), .MSG_DEPTH(M), .SCAN_DIV(2), .SCROLL_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .msg_len(msg_len), .scroll_en(scroll_en), .blank(blank),
      .sel(sel), .segm(segm), .frame_tick(frame_tick));

   task automatic wr(input logic [AW-1:0] a, input logic [13:0] v);
      wr_en = 1'b1; wr_addr = a; wr_data = v;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic sync;
      int t = 0;
      @(negedge clk);
      while (frame_tick !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      if (t >= 100) begin n_tests++; n_fail++; $display("FAIL sync: frame_tick never seen"); end
   endtask

   task automatic grab;
      for (int k = 0; k < N; k++) begin
         repeat (2) @(negedge clk);
         cs[k] = sel; cq[k] = segm;
      end
   endtask

   task automatic test_reset;
      msg_len = 4'd8;
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wr_addr = 3'(i); wr_data = 14'h3FFF; scroll_en = ~scroll_en;
         @(negedge clk);
         n_tests++;
         if (sel !== '0 || segm !== '0 || frame_tick !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold: sel=%b segm=%b ft=%b want 0", sel, segm, frame_tick);
         end
      end
      wr_en = 1'b0; scroll_en = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (sel !== '0) begin n_fail++; $display("FAIL reset_first_edge: sel=%b want 0000", sel); end
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         if (k > 0) repeat (2) @(negedge clk);
         es = 4'b0001 << (k % N);
         n_tests++;
         if (sel !== es || segm !== '0) begin
            n_fail++; $display("FAIL reset_scan %0d: sel=%b segm=%h want %b 0000", k, sel, segm, es);
         end
      end
   endtask

   task automatic test_static;
      int cnt = 0;
      wr(3'd0, 14'b11001111000000);
      wr(3'd1, 14'b11101111000000);
      msg_len = 4'd2; scroll_en = 1'b0;
      sync; grab;
      for (int k = 0; k < N; k++) begin
         es = 4'b0001 << k;
         eq = (k == 0) ? 14'b11001111000000 : (k == 1) ? 14'b11101111000000 : 14'b0;
         n_tests++;
         if (cs[k] !== es || cq[k] !== eq) begin
            n_fail++; $display("FAIL static %0d: sel=%b segm=%b want %b %b", k, cs[k], cq[k], es, eq);
         end
      end
      for (int i = 0; i < 16; i++) begin @(negedge clk); cnt += int'(frame_tick); end
      n_tests++;
      if (cnt != 2) begin n_fail++; $display("FAIL static_frame_tick: %0d pulses want 2", cnt); end
   endtask

   task automatic test_scroll_wrap;
      for (int i = 0; i < 5; i++) wr(3'(i), g[i]);
      msg_len = 4'd5; scroll_en = 1'b0;
      sync; scroll_en = 1'b1;
      for (int f = 0; f < 12; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            es = 4'b0001 << k; eq = g[((f/2)%5 + k) % 5];
            n_tests++;
            if (cs[k] !== es || cq[k] !== eq) begin
               n_fail++; $display("FAIL scroll f%0d d%0d: sel=%b segm=%h want %b %h", f, k, cs[k], cq[k], es, eq);
            end
         end
      end
   endtask

   task automatic test_short_wrap;
      scroll_en = 1'b0; msg_len = 4'd2;
      sync; scroll_en = 1'b1;
      for (int f = 0; f < 4; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            eq = g[((f/2) + k) % 2];
            n_tests++;
            if (cq[k] !== eq) begin n_fail++; $display("FAIL short f%0d d%0d: segm=%h want %h", f, k, cq[k], eq); end
         end
      end
   endtask

   task automatic test_blank;
      scroll_en = 1'b0; msg_len = 4'd5;
      sync; scroll_en = 1'b1; blank = 1'b1;
      for (int f = 0; f < 3; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            n_tests++;
            if (cs[k] !== '0 || cq[k] !== '0) begin
               n_fail++; $display("FAIL blank f%0d d%0d: sel=%b segm=%h want 0 0", f, k, cs[k], cq[k]);
            end
         end
      end
      blank = 1'b0;
      for (int f = 3; f < 5; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            es = 4'b0001 << k; eq = g[((f/2) + k) % 5];
            n_tests++;
            if (cs[k] !== es || cq[k] !== eq) begin
               n_fail++; $display("FAIL unblank f%0d d%0d: sel=%b segm=%h want %b %h", f, k, cs[k], cq[k], es, eq);
            end
         end
      end
   endtask

   task automatic test_boundaries;
      for (int i = 5; i < M; i++) wr(3'(i), g[i]);
      scroll_en = 1'b0; msg_len = 4'd12;
      sync; scroll_en = 1'b1;
      for (int f = 0; f < 16; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            eq = g[((f/2)%8 + k) % 8];
            n_tests++;
            if (cq[k] !== eq) begin n_fail++; $display("FAIL len12 f%0d d%0d: segm=%h want %h", f, k, cq[k], eq); end
         end
      end
      scroll_en = 1'b0; msg_len = 4'd0;
      sync;
      for (int f = 0; f < 2; f++) begin
         grab;
         scroll_en = 1'b1;
         for (int k = 0; k < N; k++) begin
            es = 4'b0001 << k;
            n_tests++;
            if (cs[k] !== es || cq[k] !== '0) begin
               n_fail++; $display("FAIL len0 f%0d d%0d: sel=%b segm=%h want %b 0", f, k, cs[k], cq[k], es);
            end
         end
      end
      scroll_en = 1'b0; msg_len = 4'd5;
      sync; scroll_en = 1'b1;
      for (int f = 0; f < 9; f++) grab;
      n_tests++;
      if (cq[0] !== g[4]) begin n_fail++; $display("FAIL shrink_pre: segm=%h want %h", cq[0], g[4]); end
      msg_len = 4'd2;
      for (int f = 9; f < 13; f++) begin
         grab;
         for (int k = 0; k < N; k++) begin
            eq = (f == 12) ? g[(k + 1) % 2] : g[k % 2];
            n_tests++;
            if (cq[k] !== eq) begin n_fail++; $display("FAIL shrink f%0d d%0d: segm=%h want %h", f, k, cq[k], eq); end
         end
      end
   endtask

   task automatic test_write_collision;
      logic [13:0] nw = 14'h2A55;
      scroll_en = 1'b0; msg_len = 4'd5;
      sync;
      repeat (2) @(negedge clk);
      n_tests++;
      if (segm !== g[0]) begin n_fail++; $display("FAIL coll_d0: segm=%h want %h", segm, g[0]); end
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = nw;
      @(negedge clk);
      wr_en = 1'b0;
      n_tests++;
      if (sel !== 4'b0010 || segm !== g[1]) begin
         n_fail++; $display("FAIL coll_old: sel=%b segm=%h want 0010 %h", sel, segm, g[1]);
      end
      repeat (4) @(negedge clk);
      grab;
      for (int k = 0; k < N; k++) begin
         eq = (k == 1) ? nw : g[k];
         n_tests++;
         if (cq[k] !== eq) begin n_fail++; $display("FAIL coll_new d%0d: segm=%h want %h", k, cq[k], eq); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < M; i++) g[i] = 14'(14'h0111 * (i + 1));
      test_reset;
      test_static;
      test_scroll_wrap;
      test_short_wrap;
      test_blank;
      test_boundaries;
      test_write_collision;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
